mantissa_divider: RTL and testbench
===================================

# mantissa_divider

Sequential restoring divider, the inverse of the MAC datapath's 4x4 mantissa multiplier: divides an 8-bit dividend by a 4-bit divisor, producing an 8-bit quotient and 4-bit remainder. It computes one quotient bit per cycle and uses valid/ready handshakes on both sides. It serves the FP8 divide/normalise path alongside the MAC.

## Interface
- `DIVIDEND_W`, default 8: dividend and quotient width. It is also the iteration count.
- `DIVISOR_W`, default 4: divisor and remainder width.
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: operands valid.
- `in_ready`, output, 1: divider idle and able to accept operands.
- `dividend`, input, DIVIDEND_W: unsigned numerator.
- `divisor`, input, DIVISOR_W: unsigned denominator.
- `out_valid`, output, 1: result valid.
- `out_ready`, input, 1: consumer accepts the result.
- `quotient`, output, DIVIDEND_W: unsigned quotient.
- `remainder`, output, DIVISOR_W: unsigned remainder.
- `div_by_zero`, output, 1: divisor was 0 (see Configuration).

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- **IDLE**
  - `in_ready` = 1.
  - On an edge with `in_valid` high, latch the dividend into the quotient shift register and latch the divisor.
  - Clear the partial remainder R, which is DIVISOR_W+1 bits.
  - Clear the iteration counter and go to RUN.
- **RUN**, one iteration per edge:
  - Compute R' = {R[DIVISOR_W-1:0], Q msb}.
  - Shift Q left by 1.
  - If R' >= divisor, set R = R' - divisor and Q lsb = 1.
  - Otherwise, set R = R' and Q lsb = 0.
  - After DIVIDEND_W iterations, go to DONE.
- **DONE**
  - `out_valid` = 1.
  - `quotient` = Q and `remainder` = R[DIVISOR_W-1:0].
  - Outputs stay stable until an edge with `out_ready` high, then go to IDLE.
- `in_ready` is low in RUN and DONE. A new operand is never accepted in the same cycle a result is consumed.
- For a non-zero divisor, the result must satisfy quotient*divisor + remainder == dividend and remainder < divisor.
- **Divisor 0** (both build variants): `quotient` = all ones (8'hFF) and `remainder` = dividend[DIVISOR_W-1:0]. The implementation forces these values regardless of what the iteration would produce.
- **Reset** (any state, including mid-RUN or DONE):
  - FSM goes to IDLE and the in-flight operation is discarded.
  - `out_valid` = 0, `quotient` = 0, `remainder` = 0, `div_by_zero` = 0.
  - `in_ready` = 0 while `rst` is high, and 1 on the first cycle after.

## Timing
- Operands are accepted at edge E0. Iterations run at E1 through E8. `out_valid` is high from the cycle after E8, giving 8 cycles from accept to `out_valid`.
- The result is consumed at edge Ec (`out_ready` high). `in_ready` rises the cycle after Ec.
- Best-case throughput is one division per 10 cycles with `out_ready` held high.
- `in_ready` and `out_valid` are decoded from state, with no combinational path from inputs.
- Backpressure: `out_valid` stays high with `quotient` and `remainder` unchanged for any number of cycles with `out_ready` low.

## Configuration
- Macro: `DIVIDER_ZERO_BYPASS_EN`.
- **Defined**
  - When the divisor is 0 at accept, the FSM goes IDLE to DONE directly, skipping RUN. `out_valid` is high 1 cycle after accept.
  - `div_by_zero` = 1 while in DONE for that operation, and 0 otherwise.
- **Undefined**
  - A divisor of 0 runs the full 8 iterations. Final outputs are forced to the divisor-0 values.
  - `div_by_zero` is tied to 0.

## Test plan
- 200 / 7 with `out_ready` held high: `quotient` = 28 and `remainder` = 4. `out_valid` is high exactly 8 cycles after accept. `in_ready` is low during RUN and DONE.
- 255 / 1 gives 255 rem 0. 5 / 9 gives 0 rem 5. 0 / 15 gives 0 rem 0. Sweep all 4096 operand pairs and check the divide identity against a reference model.
- 0xA5 / 0: `quotient` = 0xFF and `remainder` = 5.
  - With `DIVIDER_ZERO_BYPASS_EN`: `out_valid` 1 cycle after accept, `div_by_zero` = 1.
  - Without it: `out_valid` 8 cycles after accept, `div_by_zero` = 0.
- Backpressure: 100 / 3 with `out_ready` low for 5 cycles. `quotient` = 33 and `remainder` = 1 hold stable throughout, and `in_valid` pulses are ignored. Raising `out_ready` gives one handshake, then `in_ready` = 1 the next cycle.
- Reset mid-operation: assert `rst` at iteration 4 of 200 / 7. The next cycle shows `out_valid` = 0 and outputs at 0. After release, a fresh 9 / 2 gives 4 rem 1 with no residue from the aborted run.

Source files
------------

// File: rtl/mantissa_divider.sv
// mantissa_divider: sequential restoring divider, one quotient bit per cycle, valid/ready on both sides.
// Optional feature macro DIVIDER_ZERO_BYPASS_EN: a zero divisor skips the iterations and raises div_by_zero.
module mantissa_divider #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int               CNT_W     = $clog2(DIVIDEND_W + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIVIDEND_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                state_r;
    state_t                state_next_s;

    logic [DIVIDEND_W-1:0] q_r;
    logic [DIVISOR_W:0]    r_r;
    logic [DIVISOR_W-1:0]  d_r;
    logic [CNT_W-1:0]      cnt_r;
    logic                  zero_r;
    logic [DIVISOR_W-1:0]  rem_force_r;

    logic                  in_ready_r;
    logic                  out_valid_r;
    logic [DIVIDEND_W-1:0] quotient_r;
    logic [DIVISOR_W-1:0]  remainder_r;

    logic                  accept_s;
    logic                  consume_s;
    logic                  last_iter_s;
    logic                  divisor_zero_s;
    logic                  bypass_s;
    logic                  sub_ok_s;
    logic [DIVISOR_W:0]    r_shift_s;
    logic [DIVISOR_W:0]    r_iter_s;
    logic [DIVIDEND_W-1:0] q_iter_s;
    logic [DIVIDEND_W-1:0] q_final_s;
    logic [DIVISOR_W-1:0]  r_final_s;

    assign accept_s       = (state_r == ST_IDLE) && in_ready_r && in_valid;
    assign consume_s      = (state_r == ST_DONE) && out_ready;
    assign last_iter_s    = (cnt_r == LAST_ITER);
    assign divisor_zero_s = (divisor == {DIVISOR_W{1'b0}});

`ifdef DIVIDER_ZERO_BYPASS_EN
    assign bypass_s = accept_s && divisor_zero_s;
`else
    assign bypass_s = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bypass_s) begin
                    state_next_s = ST_DONE;
                end else if (accept_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_iter_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // One restoring step; R never exceeds the divisor so DIVISOR_W+1 bits suffice
    always_comb begin
        r_shift_s = {r_r[DIVISOR_W-1:0], q_r[DIVIDEND_W-1]};
        sub_ok_s  = (r_shift_s >= {1'b0, d_r});
        if (sub_ok_s) begin
            r_iter_s = r_shift_s - {1'b0, d_r};
        end else begin
            r_iter_s = r_shift_s;
        end
        q_iter_s = {q_r[DIVIDEND_W-2:0], sub_ok_s};
    end

    // Final result, with the divide-by-zero values overriding whatever the iterations produced
    always_comb begin
        if (zero_r) begin
            q_final_s = {DIVIDEND_W{1'b1}};
            r_final_s = rem_force_r;
        end else begin
            q_final_s = q_iter_s;
            r_final_s = r_iter_s[DIVISOR_W-1:0];
        end
    end

    // Working registers: operand capture and iteration
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r         <= {DIVIDEND_W{1'b0}};
            r_r         <= {(DIVISOR_W + 1){1'b0}};
            d_r         <= {DIVISOR_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            zero_r      <= 1'b0;
            rem_force_r <= {DIVISOR_W{1'b0}};
        end else if (accept_s) begin
            q_r         <= dividend;
            r_r         <= {(DIVISOR_W + 1){1'b0}};
            d_r         <= divisor;
            cnt_r       <= {CNT_W{1'b0}};
            zero_r      <= divisor_zero_s;
            rem_force_r <= dividend[DIVISOR_W-1:0];
        end else if (state_r == ST_RUN) begin
            q_r   <= q_iter_s;
            r_r   <= r_iter_s;
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            q_r   <= q_r;
            r_r   <= r_r;
            cnt_r <= cnt_r;
        end
    end

    // Handshake flags follow the next state so they are pure flops
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            in_ready_r  <= (state_next_s == ST_IDLE);
            out_valid_r <= (state_next_s == ST_DONE);
        end
    end

    // Result registers load on entry to DONE and hold through backpressure
    always_ff @(posedge clk) begin
        if (rst) begin
            quotient_r  <= {DIVIDEND_W{1'b0}};
            remainder_r <= {DIVISOR_W{1'b0}};
        end else if (bypass_s) begin
            quotient_r  <= {DIVIDEND_W{1'b1}};
            remainder_r <= dividend[DIVISOR_W-1:0];
        end else if ((state_r == ST_RUN) && last_iter_s) begin
            quotient_r  <= q_final_s;
            remainder_r <= r_final_s;
        end else begin
            quotient_r  <= quotient_r;
            remainder_r <= remainder_r;
        end
    end

`ifdef DIVIDER_ZERO_BYPASS_EN
    logic div_by_zero_r;

    // Flag is scoped to the DONE residency of the bypassed operation
    always_ff @(posedge clk) begin
        if (rst) begin
            div_by_zero_r <= 1'b0;
        end else if (bypass_s) begin
            div_by_zero_r <= 1'b1;
        end else if (consume_s) begin
            div_by_zero_r <= 1'b0;
        end else begin
            div_by_zero_r <= div_by_zero_r;
        end
    end

    assign div_by_zero = div_by_zero_r;
`else
    assign div_by_zero = 1'b0;
`endif

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign quotient  = quotient_r;
    assign remainder = remainder_r;

endmodule

// File: tb/tb_mantissa_divider.sv
// Scoreboard bench for mantissa_divider: driver pushes reference results, a negedge monitor pops and compares.
module tb_mantissa_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    mantissa_divider dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        int q;
        int r;
        int dbz;
        int lat;
        int acc;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   rand_ready  = 1'b0;
    bit   ready_force = 1'b1;
    bit   prev_valid  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int ref_q(input int a, input int b);
        return (b == 0) ? 255 : a / b;
    endfunction

    function automatic int ref_r(input int a, input int b);
        return (b == 0) ? (a % 16) : (a % b);
    endfunction

    // Consumer side: out_ready changes just after the rising edge
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
        end
    end

    // Monitor: compare every presented result, pop on handshake
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q[0];
                    if (!prev_valid) check($sformatf("latency_%0d/%0d", e.a, e.b), cyc - e.acc, e.lat);
                    check($sformatf("quotient_%0d/%0d", e.a, e.b), int'(quotient), e.q);
                    check($sformatf("remainder_%0d/%0d", e.a, e.b), int'(remainder), e.r);
                    check($sformatf("div_by_zero_%0d/%0d", e.a, e.b), int'(div_by_zero), e.dbz);
                    check("in_ready_in_done", int'(in_ready), 0);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            prev_valid = out_valid;
        end
    end

    task automatic issue(input int a, input int b, input int q, input int r);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 0, 1);
        end else begin
            in_valid = 1'b1;
            dividend = 8'(a);
            divisor  = 4'(b);
            e.a = a; e.b = b; e.q = q; e.r = r;
`ifdef DIVIDER_ZERO_BYPASS_EN
            e.lat = (b == 0) ? 1 : 8;
            e.dbz = (b == 0) ? 1 : 0;
`else
            e.lat = 8;
            e.dbz = 0;
`endif
            e.acc = cyc + 1;
            exp_q.push_back(e);
            @(negedge clk);
            in_valid = 1'b0;
            check("in_ready_after_accept", int'(in_ready), 0);
        end
    endtask

    initial begin
        int n;
        rst      = 1'b1;
        in_valid = 1'b0;
        dividend = 8'd0;
        divisor  = 4'd0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_quotient", int'(quotient), 0);
        check("reset_remainder", int'(remainder), 0);
        check("reset_div_by_zero", int'(div_by_zero), 0);
        check("reset_in_ready", int'(in_ready), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("in_ready_after_reset", int'(in_ready), 1);

        // Directed cases with out_ready held high
        issue(200, 7, 28, 4);
        issue(255, 1, 255, 0);
        issue(5, 9, 0, 5);
        issue(0, 15, 0, 0);
        issue(165, 0, 255, 5);

        // Backpressure: 100/3 held for 5 cycles while stray in_valid pulses arrive
        n = 0;
        while (out_valid || exp_q.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > 50) break;
        end
        ready_force = 1'b0;
        issue(100, 3, 33, 1);
        n = 0;
        while (!out_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("bp_out_valid_seen", int'(out_valid), 1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            dividend = 8'(17 * (i + 1));
            divisor  = 4'(i + 2);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("bp_still_valid", int'(out_valid), 1);
        check("bp_queue_depth", exp_q.size(), 1);
        ready_force = 1'b1;
        n = 0;
        @(negedge clk);
        while (out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("bp_out_valid_dropped", int'(out_valid), 0);
        check("bp_in_ready_after_consume", int'(in_ready), 1);
        check("bp_single_handshake", exp_q.size(), 0);

        // Reset at iteration 4 of 200/7, then a clean 9/2
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 8'd200;
        divisor  = 4'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrun_reset_out_valid", int'(out_valid), 0);
        check("midrun_reset_quotient", int'(quotient), 0);
        check("midrun_reset_remainder", int'(remainder), 0);
        check("midrun_reset_div_by_zero", int'(div_by_zero), 0);
        check("midrun_reset_in_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrun_in_ready_after_release", int'(in_ready), 1);
        check("midrun_no_result", int'(out_valid), 0);
        issue(9, 2, 4, 1);

        // Exhaustive sweep, then randomized operands under random backpressure
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                issue(a, b, ref_q(a, b), ref_r(a, b));
            end
        end
        rand_ready = 1'b1;
        for (int k = 0; k < 300; k++) begin
            int a;
            int b;
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 15));
            issue(a, b, ref_q(a, b), ref_r(a, b));
        end
        rand_ready = 1'b0;

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, %0d results outstanding", exp_q.size());
        $fatal(1, "watchdog");
    end

endmodule
